// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature sensor path.
// The averager also imports this package for its sample type.
package temp_pkg;

  localparam int unsigned TEMP_W  = 10;
  localparam int unsigned FRAME_W = 12;
  localparam logic [1:0]  HDR_OK  = 2'b10;

  // Reader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE
  } reader_state_t;

  // A reading as consumed by the averager.
  typedef logic signed [TEMP_W-1:0] temp_sample_t;

  // True when the frame carries the expected 2-bit header.
  function automatic logic frame_hdr_ok(input logic [FRAME_W-1:0] frame);
    return frame[FRAME_W-1 -: 2] == HDR_OK;
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// Serial clock generator for the sensor interface.
// It counts CLK_DIV-cycle half-periods while enabled. sclk toggles only while
// gated (SHIFT), so the SETUP half-period stays low. The pulses are asserted
// in the cycle whose closing edge drives sclk 0->1 or 1->0.
module sclk_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic gate,
  output logic sclk,
  output logic half_done,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [7:0] HALF_MAX = 8'(CLK_DIV - 1);

  logic [7:0] r_hcnt;
  logic       r_sclk;
  logic       w_wrap;

  assign w_wrap     = en && (r_hcnt == HALF_MAX);
  assign half_done  = w_wrap;
  assign rise_pulse = w_wrap && gate && !r_sclk;
  assign fall_pulse = w_wrap && gate && r_sclk;
  assign sclk       = r_sclk;

  // Half-period counter and sclk toggle register; both idle at zero when disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_sclk <= 1'b0;
    end else if (!en) begin
      r_hcnt <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_hcnt <= '0;
      if (gate) begin
        r_sclk <= ~r_sclk;
      end
    end else begin
      r_hcnt <= r_hcnt + 8'd1;
    end
  end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic SPI (mode 0, MSB first) reader for a 12-bit temperature frame.
// A frame with a good header is presented on tempvalue with a one-cycle
// shift_en strobe. A bad header raises a one-cycle frame_err instead.
module temp_sensor_reader
  import temp_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned DATA_W        = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     miso,
  output logic                     cs_n,
  output logic                     sclk,
  output logic signed [DATA_W-1:0] tempvalue,
  output logic                     shift_en,
  output logic                     frame_err,
  output logic                     busy
);

  localparam logic [15:0] WAIT_FROM_IDLE = 16'(SAMPLE_PERIOD);
  localparam logic [15:0] WAIT_FROM_DONE = 16'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]  BIT_MSB        = 4'(FRAME_W - 1);

  reader_state_t             r_state;
  logic [15:0]               r_wcnt;
  logic [3:0]                r_bitcnt;
  logic [FRAME_W-1:0]        r_sr;
  logic                      r_cs_n;
  logic signed [DATA_W-1:0]  r_temp;
  logic                      r_shift_en;
  logic                      r_frame_err;
  logic                      r_busy;

  logic w_div_en;
  logic w_div_gate;
  logic w_half_done;
  logic w_rise;
  logic w_fall;
  logic w_sclk;

  assign w_div_en   = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
  assign w_div_gate = (r_state == ST_SHIFT);

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (w_div_en),
    .gate       (w_div_gate),
    .sclk       (w_sclk),
    .half_done  (w_half_done),
    .rise_pulse (w_rise),
    .fall_pulse (w_fall)
  );

  assign cs_n      = r_cs_n;
  assign sclk      = w_sclk;
  assign tempvalue = r_temp;
  assign shift_en  = r_shift_en;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

  // Frame sequencer: wait period, chip select, bit capture and result strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= '0;
      r_bitcnt    <= '0;
      r_sr        <= '0;
      r_cs_n      <= 1'b1;
      r_temp      <= '0;
      r_shift_en  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_shift_en  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cs_n <= 1'b1;
          r_busy <= 1'b0;
          if (enable) begin
            // Down-counter reaches SETUP after count+1 WAIT cycles: leaving IDLE
            // takes one cycle more than the steady-state DONE->WAIT path.
            r_wcnt  <= WAIT_FROM_IDLE;
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!enable) begin
            r_wcnt  <= '0;
            r_state <= ST_IDLE;
          end else if (r_wcnt == '0) begin
            r_cs_n   <= 1'b0;
            r_busy   <= 1'b1;
            r_bitcnt <= BIT_MSB;
            r_state  <= ST_SETUP;
          end else begin
            r_wcnt <= r_wcnt - 16'd1;
          end
        end

        ST_SETUP: begin
          if (w_half_done) begin
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_rise) begin
            r_sr <= {r_sr[FRAME_W-2:0], miso};
          end
          if (w_fall) begin
            if (r_bitcnt == '0) begin
              // Final high phase ends here, sclk falls on the same edge as cs_n rises.
              r_cs_n  <= 1'b1;
              r_state <= ST_DONE;
              if (frame_hdr_ok(r_sr)) begin
                r_temp     <= r_sr[DATA_W-1:0];
                r_shift_en <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt - 4'd1;
            end
          end
        end

        ST_DONE: begin
          r_busy <= 1'b0;
          if (enable) begin
            r_wcnt  <= WAIT_FROM_DONE;
            r_state <= ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Self-checking bench for temp_sensor_reader with a mode-0 sensor model and
// an event scoreboard.
module tb_temp_sensor_reader;

  localparam int unsigned CD  = 2;
  localparam int unsigned SP  = 10;
  localparam int unsigned LAT = 25 * CD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic miso = 1'b0;
  logic cs_n, sclk, shift_en, frame_err, busy;
  logic signed [9:0] tempvalue;

  temp_sensor_reader #(
    .CLK_DIV       (CD),
    .SAMPLE_PERIOD (SP),
    .DATA_W        (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .miso      (miso),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .tempvalue (tempvalue),
    .shift_en  (shift_en),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [9:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] frame_q[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned cyc = 0;
  int unsigned cs_fall_cnt = 0;
  int unsigned cs_fall_cyc = 0;
  int unsigned ev_cnt = 0;
  int unsigned strobe_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned last_ev_cyc = 0;
  int unsigned rises = 0;
  int unsigned hi_run = 0;
  int unsigned lo_run = 0;
  int          bitidx = 0;
  logic [11:0] cur = '0;
  logic [9:0]  model_temp = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Sensor model, sclk/cs_n protocol checks and event scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_temp = '0;
      rises  = 0;
      hi_run = 0;
      lo_run = 0;
    end else begin
      if (prev_cs && !cs_n) begin
        cs_fall_cnt++;
        cs_fall_cyc = cyc;
        if (frame_q.size() > 0) cur = frame_q.pop_front();
        else cur = {2'b10, 10'($urandom)};
        exp_q.push_back('{is_err: (cur[11:10] != 2'b10), val: cur[9:0]});
        bitidx = 11;
        miso   = cur[11];
        rises  = 0;
        hi_run = 0;
        lo_run = 1;
      end else if (!prev_sclk && sclk) begin
        check_eq("sclk_low_phase", lo_run, (rises == 0) ? 2 * CD : CD);
        rises++;
        lo_run = 0;
        hi_run = 1;
      end else if (prev_sclk && !sclk) begin
        check_eq("sclk_high_phase", hi_run, CD);
        hi_run = 0;
        lo_run = cs_n ? 0 : 1;
        if (!cs_n && bitidx > 0) begin
          bitidx--;
          miso = cur[bitidx];
        end
      end else if (sclk) begin
        hi_run++;
      end else if (!cs_n) begin
        lo_run++;
      end

      if (!prev_cs && cs_n) begin
        check_eq("cs_rise_sclk", sclk, 0);
        check_eq("rises_per_frame", rises, 12);
      end
      check_eq("sclk_while_cs_high", sclk & cs_n, 0);
      check_eq("strobe_exclusive", shift_en & frame_err, 0);
      if (!cs_n) check_eq("busy_in_frame", busy, 1);

      if (shift_en || frame_err) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("event_kind_err", frame_err, e.is_err);
          check_eq("event_latency", cyc - cs_fall_cyc, LAT);
          check_eq("busy_in_done", busy, 1);
          if (!e.is_err) model_temp = e.val;
        end
        ev_cnt++;
        if (shift_en) strobe_cnt++;
        if (frame_err) err_cnt++;
        last_ev_cyc = cyc;
      end
      check_eq("tempvalue", 32'($unsigned(tempvalue)), 32'(model_temp));
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_events(input int unsigned target, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (ev_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (ev_cnt < target) check_eq(tag, ev_cnt, target);
  endtask

  task automatic wait_cs(input int unsigned target, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (cs_fall_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (cs_fall_cnt < target) check_eq(tag, cs_fall_cnt, target);
  endtask

  task automatic wait_rises(input int unsigned target, input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (rises < target && n < budget) begin
      tick();
      n++;
    end
    if (rises < target) check_eq(tag, rises, target);
  endtask

  initial begin
    int unsigned t0, t1, t2, c0, e0, s0, r0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("rst_cs_n", cs_n, 1);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_temp", 32'($unsigned(tempvalue)), 0);
    check_eq("rst_shift_en", shift_en, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_busy", busy, 0);

    // Negative reading, first-frame delay and strobe width.
    frame_q.push_back(12'b10_1111100111);
    @(posedge clk);
    #1;
    t0 = cyc;
    enable = 1'b1;
    wait_cs(1, 100, "s1_cs_timeout");
    check_eq("first_cs_delay", cs_fall_cyc - t0, SP + 2);
    wait_events(1, 200, "s1_timeout");
    check_eq("s1_temp", 32'($unsigned(tempvalue)), 32'h3E7);
    check_eq("s1_latency", last_ev_cyc - cs_fall_cyc, 50);
    t0 = last_ev_cyc;
    frame_q.push_back(12'b10_0111111111);
    frame_q.push_back(12'b10_1000000000);
    tick();
    check_eq("s1_strobe_width", shift_en, 0);

    // Extremes on consecutive strobes, steady-state spacing.
    wait_events(2, 200, "s2a_timeout");
    t1 = last_ev_cyc;
    check_eq("s2_temp_max", 32'($unsigned(tempvalue)), 32'h1FF);
    wait_events(3, 200, "s2b_timeout");
    t2 = last_ev_cyc;
    enable = 1'b0;
    check_eq("s2_temp_min", 32'($unsigned(tempvalue)), 32'h200);
    check_eq("s2_spacing_a", t1 - t0, 61);
    check_eq("s2_spacing_b", t2 - t1, 61);
    c0 = cs_fall_cnt;
    repeat (40) tick();
    check_eq("s2_no_frame_after_disable", cs_fall_cnt, c0);

    // Bad header: error strobe only, reading held.
    e0 = err_cnt;
    s0 = strobe_cnt;
    frame_q.push_back(12'b01_0001010101);
    enable = 1'b1;
    wait_events(4, 200, "s3_timeout");
    enable = 1'b0;
    check_eq("s3_err_count", err_cnt - e0, 1);
    check_eq("s3_no_strobe", strobe_cnt - s0, 0);
    check_eq("s3_temp_held", 32'($unsigned(tempvalue)), 32'h200);
    tick();
    check_eq("s3_err_width", frame_err, 0);
    repeat (40) tick();

    // Enable dropped during bit 6: frame completes, then IDLE for good.
    frame_q.push_back(12'b10_0000101010);
    c0 = cs_fall_cnt;
    enable = 1'b1;
    wait_cs(c0 + 1, 100, "s4_cs_timeout");
    wait_rises(6, 100, "s4_rise_timeout");
    enable = 1'b0;
    wait_events(5, 200, "s4_timeout");
    check_eq("s4_temp", 32'($unsigned(tempvalue)), 32'h02A);
    c0 = cs_fall_cnt;
    repeat (3 * (SP + LAT)) tick();
    check_eq("s4_no_more_cs", cs_fall_cnt, c0);
    check_eq("s4_busy_idle", busy, 0);

    // Reset during SHIFT: immediate reset values, no strobe.
    frame_q.push_back(12'b10_0000000111);
    c0 = cs_fall_cnt;
    enable = 1'b1;
    wait_cs(c0 + 1, 100, "s5_cs_timeout");
    wait_rises(4, 100, "s5_rise_timeout");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    tick();
    check_eq("s5_cs_n", cs_n, 1);
    check_eq("s5_sclk", sclk, 0);
    check_eq("s5_temp", 32'($unsigned(tempvalue)), 0);
    check_eq("s5_shift_en", shift_en, 0);
    check_eq("s5_busy", busy, 0);
    enable = 1'b0;
    rst_n  = 1'b1;
    r0 = ev_cnt;
    repeat (100) tick();
    check_eq("s5_no_strobe", ev_cnt, r0);

    // Twenty random frames back to back, occasionally with a bad header.
    for (int i = 0; i < 20; i++) begin
      logic [1:0] hdr;
      hdr = ($urandom_range(0, 4) == 0) ? 2'b11 : 2'b10;
      frame_q.push_back({hdr, 10'($urandom)});
    end
    r0 = ev_cnt;
    enable = 1'b1;
    wait_events(r0 + 20, 20 * 80, "s6_timeout");
    enable = 1'b0;
    repeat (20) tick();
    check_eq("s6_frames_consumed", frame_q.size(), 0);
    check_eq("s6_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
